// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider: FSM state encoding,
// the divide-by-zero quotient pattern and the channel wrap rule.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int unsigned MAX_W = 64;

    // All-ones pattern of width w; callers truncate to their own WIDTH.
    function automatic logic [MAX_W-1:0] div0_quotient(input int unsigned w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic int unsigned next_ch(input int unsigned sel, input int unsigned num_ch);
        return (sel + 1 >= num_ch) ? 0 : sel + 1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor and keep the result if it did not borrow.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem, q[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider_mux.sv
// Multi-cycle channel-select divider: channel k divides operand k by operand
// k+1 (wrapping), one quotient bit per clock behind a start/busy/done handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start
//   RUN   | one restoring step per clock, WIDTH steps
//   FIN   | results valid, done high for one cycle; may accept a new start
module seq_divider_mux
    import div_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] operands,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        quotient,
    output logic [WIDTH-1:0]        remainder,
    output logic                    error
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = WIDTH'(div0_quotient(WIDTH));

    state_t state, state_n;

    logic [WIDTH-1:0] ch_op [NUM_CH];
    logic             sel_ok;
    logic [SEL_W-1:0] nxt_idx;
    logic [WIDTH-1:0] dividend_sel;
    logic [WIDTH-1:0] divisor_sel;
    logic             div0;
    logic             accept;

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] divisor_r;
    logic [CNT_W-1:0] cnt;
    logic             last;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] q_n;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            ch_op[k] = operands[k*WIDTH +: WIDTH];
        end
    end

    // An out-of-range select (only possible for non-power-of-2 NUM_CH)
    // yields a zero divisor and so takes the divide-by-zero path.
    always_comb begin
        sel_ok       = (32'(sel) < NUM_CH);
        nxt_idx      = SEL_W'(next_ch(32'(sel), NUM_CH));
        dividend_sel = sel_ok ? ch_op[sel]     : '0;
        divisor_sel  = sel_ok ? ch_op[nxt_idx] : '0;
        div0         = (divisor_sel == '0);
        accept       = start && (state != RUN);
        last         = (cnt == CNT_W'(WIDTH - 1));
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_r),
        .q        (q_r),
        .divisor  (divisor_r),
        .rem_next (rem_n),
        .q_next   (q_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) state_n = div0 ? FIN : RUN;
            end
            RUN: begin
                if (last) state_n = FIN;
            end
            FIN: begin
                if (accept) state_n = div0 ? FIN : RUN;
                else        state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Result registers load only on the edge entering FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r     <= '0;
            q_r       <= '0;
            divisor_r <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            error     <= 1'b0;
        end else if (accept) begin
            if (div0) begin
                quotient  <= DIV0_QUOTIENT;
                remainder <= dividend_sel;
                error     <= 1'b1;
            end else begin
                rem_r     <= '0;
                q_r       <= dividend_sel;
                divisor_r <= divisor_sel;
                cnt       <= '0;
            end
        end else if (state == RUN) begin
            rem_r <= rem_n;
            q_r   <= q_n;
            cnt   <= cnt + 1'b1;
            if (last) begin
                quotient  <= q_n;
                remainder <= rem_n;
                error     <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == FIN);

endmodule

// File: tb/tb_seq_divider_mux.sv
// Directed and reference-model bench for seq_divider_mux (WIDTH=8, NUM_CH=4).
module tb_seq_divider_mux;

    localparam int WIDTH  = 8;
    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  sel = '0;
    logic [31:0] operands = '0;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        error;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_divider_mux #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .operands  (operands),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [1:0] s, input logic [31:0] ops);
        @(negedge clk);
        start    = 1'b1;
        sel      = s;
        operands = ops;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Called after the accept edge; returns at the negedge where done is seen.
    task automatic wait_done(output int busy_cycles, output bit got);
        busy_cycles = 0;
        got         = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else if (busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, error} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: busy/done/error=%b expected 000", {busy, done, error});
        end
        n_cmp++;
        if (quotient !== 8'd0 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_results: q=%0d r=%0d expected 0 0", quotient, remainder);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy/done=%b expected 00", {busy, done});
        end
    endtask

    task automatic test_basic();
        int bc;
        bit got;
        issue(2'd0, {8'd0, 8'd0, 8'd7, 8'd100});
        wait_done(bc, got);
        n_cmp++;
        if (!got || bc != 8) begin
            n_fail++;
            $display("FAIL basic_latency: got_done=%0d busy_cycles=%0d expected 1 8", got, bc);
        end
        n_cmp++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: q=%0d r=%0d err=%b expected 14 2 0", quotient, remainder, error);
        end
    endtask

    task automatic test_wrap();
        int bc;
        bit got;
        issue(2'd3, {8'd255, 8'd0, 8'd0, 8'd16});
        wait_done(bc, got);
        n_cmp++;
        if (!got || quotient !== 8'd15 || remainder !== 8'd15 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_result: done=%0d q=%0d r=%0d err=%b expected 1 15 15 0",
                     got, quotient, remainder, error);
        end
    endtask

    task automatic test_div0();
        issue(2'd1, {8'd0, 8'd0, 8'd42, 8'd0});
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_latency: done=%b busy=%b expected 1 0", done, busy);
        end
        n_cmp++;
        if (quotient !== 8'd255 || remainder !== 8'd42 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL div0_result: q=%0d r=%0d err=%b expected 255 42 1", quotient, remainder, error);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL div0_single_pulse: done=%b expected 0", done);
        end
    endtask

    task automatic test_busy_ignore();
        int ndone = 0;
        logic [7:0] q_seen = '0;
        logic [7:0] r_seen = '0;
        issue(2'd0, {8'd0, 8'd0, 8'd3, 8'd200});
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 2) begin
                n_cmp++;
                if (busy !== 1'b1 || quotient !== 8'd255 || remainder !== 8'd42 || error !== 1'b1) begin
                    n_fail++;
                    $display("FAIL busy_hold: busy=%b q=%0d r=%0d err=%b expected 1 255 42 1",
                             busy, quotient, remainder, error);
                end
            end
            if (k == 3) begin
                start    = 1'b1;
                sel      = 2'd2;
                operands = {8'd5, 8'd10, 8'd77, 8'd9};
            end
            if (k == 6) start = 1'b0;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    q_seen = quotient;
                    r_seen = remainder;
                end
            end
        end
        n_cmp++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL busy_done_count: dones=%0d expected 1", ndone);
        end
        n_cmp++;
        if (q_seen !== 8'd66 || r_seen !== 8'd2) begin
            n_fail++;
            $display("FAIL busy_result: q=%0d r=%0d expected 66 2", q_seen, r_seen);
        end
    endtask

    task automatic test_back_to_back();
        int bc;
        bit got;
        int gap;
        @(negedge clk);
        start    = 1'b1;
        sel      = 2'd0;
        operands = {8'd0, 8'd0, 8'd1, 8'd255};
        @(posedge clk);
        @(negedge clk);
        operands = {8'd0, 8'd0, 8'd255, 8'd1};
        wait_done(bc, got);
        n_cmp++;
        if (!got || quotient !== 8'd255 || remainder !== 8'd0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: done=%0d q=%0d r=%0d err=%b expected 1 255 0 0",
                     got, quotient, remainder, error);
        end
        @(posedge clk);
        #1 start = 1'b0;
        gap = 0;
        got = 1'b0;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                gap = i;
            end
        end
        n_cmp++;
        if (!got || gap != 9) begin
            n_fail++;
            $display("FAIL b2b_spacing: done=%0d gap=%0d expected 1 9", got, gap);
        end
        n_cmp++;
        if (quotient !== 8'd0 || remainder !== 8'd1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: q=%0d r=%0d err=%b expected 0 1 0", quotient, remainder, error);
        end
    endtask

    task automatic test_random();
        int bc;
        bit got;
        logic [31:0] ops;
        logic [1:0]  s;
        int          dch;
        logic [7:0]  a, b, eq, er;
        logic        ee;
        for (int i = 0; i < 1000; i++) begin
            ops = $urandom();
            s   = 2'($urandom_range(0, 3));
            dch = (int'(s) + 1) % NUM_CH;
            if (i % 16 == 0) ops[dch*8 +: 8] = 8'd0;
            a = ops[int'(s)*8 +: 8];
            b = ops[dch*8 +: 8];
            if (b == 8'd0) begin
                eq = 8'd255; er = a; ee = 1'b1;
            end else begin
                eq = a / b; er = a % b; ee = 1'b0;
            end
            issue(s, ops);
            wait_done(bc, got);
            n_cmp++;
            if (!got || quotient !== eq || remainder !== er || error !== ee) begin
                n_fail++;
                $display("FAIL random_%0d: sel=%0d %0d/%0d done=%0d q=%0d r=%0d err=%b expected %0d %0d %b",
                         i, s, a, b, got, quotient, remainder, error, eq, er, ee);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bc;
        bit got;
        int ndone = 0;
        issue(2'd0, {8'd0, 8'd0, 8'd7, 8'd100});
        wait_done(bc, got);
        issue(2'd0, {8'd0, 8'd0, 8'd3, 8'd200});
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, error} !== 3'b000 || quotient !== 8'd0 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: busy/done/err=%b q=%0d r=%0d expected 000 0 0",
                     {busy, done, error}, quotient, remainder);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: dones=%0d expected 0", ndone);
        end
        issue(2'd0, {8'd0, 8'd0, 8'd3, 8'd9});
        wait_done(bc, got);
        n_cmp++;
        if (!got || quotient !== 8'd3 || remainder !== 8'd0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: done=%0d q=%0d r=%0d err=%b expected 1 3 0 0",
                     got, quotient, remainder, error);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_div0();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
